// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package multdiv_pkg;

  // Default watchdog limit, in cycles from unit start to unit ready.
  localparam int DEFAULT_MAX_CYCLES = 40;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    MULT_WAIT,
    DIV_WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_t;

endpackage

// File: rtl/watchdog_counter.sv
// Clearable, enabled up-counter that flags the MAX_CYCLES-th enabled cycle.
module watchdog_counter #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The first enabled cycle sees count 0, so the MAX_CYCLES-th one sees MAX_CYCLES-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; clear (or reset) restarts from zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one multiply or divide at a time through the shared units,
// with a watchdog, abort-on-new-command and a pipeline stall line.
//
// Unit handshake: mult_start/div_start is a one-cycle request; unit_opA/opB
// stay stable until the next command. The unit answers with a one-cycle
// ready whose data is valid only in that cycle. Readies are ignored unless
// the FSM is waiting on that specific unit.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic        mult_start,
  output logic        div_start,
  output logic [31:0] unit_opA,
  output logic [31:0] unit_opB,
  input  logic        mult_ready,
  input  logic [63:0] mult_product,
  input  logic        div_ready,
  input  logic [31:0] div_quotient,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        stall,
  output state_t      dbg_state
);

  state_t      state, state_n;
  op_t         op, op_n;
  logic        cmd, div_zero, latch, capture, expired, waiting, mult_ovf;
  logic [31:0] res_n;
  logic        exc_n;

  assign cmd      = ctrl_MULT || ctrl_DIV;
  assign div_zero = !ctrl_MULT && ctrl_DIV && (data_operandB == 32'd0);
  assign waiting  = (state == MULT_WAIT) || (state == DIV_WAIT);
  // Signed overflow: the upper half is not a pure sign extension of bit 31.
  assign mult_ovf = mult_product[63:32] != {32{mult_product[31]}};

  watchdog_counter #(
    .MAX_CYCLES(MAX_CYCLES),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == LAUNCH),
    .enable (waiting),
    .expired(expired)
  );

  // Next-state and capture decode; a new command overrides whatever is in flight.
  always_comb begin
    state_n = state;
    op_n    = op;
    latch   = 1'b0;
    capture = 1'b0;
    res_n   = 32'd0;
    exc_n   = 1'b0;
    if (cmd) begin
      latch = 1'b1;
      op_n  = ctrl_MULT ? OP_MULT : OP_DIV;
      if (div_zero) begin
        state_n = DONE;
        capture = 1'b1;
        exc_n   = 1'b1;
      end else begin
        state_n = LAUNCH;
      end
    end else begin
      case (state)
        IDLE:   state_n = IDLE;
        LAUNCH: state_n = (op == OP_MULT) ? MULT_WAIT : DIV_WAIT;
        MULT_WAIT: begin
          if (mult_ready) begin
            state_n = DONE;
            capture = 1'b1;
            res_n   = mult_product[31:0];
            exc_n   = mult_ovf;
          end else if (expired) begin
            state_n = DONE;
            capture = 1'b1;
            exc_n   = 1'b1;
          end
        end
        DIV_WAIT: begin
          if (div_ready) begin
            state_n = DONE;
            capture = 1'b1;
            res_n   = div_quotient;
          end else if (expired) begin
            state_n = DONE;
            capture = 1'b1;
            exc_n   = 1'b1;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State, operand latch and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      op             <= OP_MULT;
      unit_opA       <= 32'd0;
      unit_opB       <= 32'd0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
    end else begin
      state <= state_n;
      op    <= op_n;
      if (latch) begin
        unit_opA <= data_operandA;
        unit_opB <= data_operandB;
      end
      if (capture) begin
        data_result    <= res_n;
        data_exception <= exc_n;
      end
    end
  end

  assign mult_start     = (state == LAUNCH) && (op == OP_MULT);
  assign div_start      = (state == LAUNCH) && (op == OP_DIV);
  assign data_resultRDY = (state == DONE);
  assign stall          = ((state == IDLE) && cmd) || (state == LAUNCH) || waiting;
  assign dbg_state      = state;

endmodule
